// File: rtl/bridge_uart_frame_decoder.sv
// UART bridge receive framing: parses SOF/CMD/ADDR/[DATA]/[CHK] requests into a show-ahead FIFO.
// Define BRIDGE_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module bridge_uart_frame_decoder #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd5000,
    parameter logic [7:0]  SOF_BYTE       = 8'h7E
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic        frm_rw,
    output logic [15:0] frm_addr,
    output logic [7:0]  frm_data,
    output logic        busy,
    output logic [7:0]  err_count,
    output logic [7:0]  drop_count,
    output logic [2:0]  dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_AHI  = 3'd2,
        S_ALO  = 3'd3,
        S_DATA = 3'd4,
        S_CHK  = 3'd5
    } state_t;

`ifdef BRIDGE_FRAME_CHECKSUM_EN
    localparam state_t FRAME_END = S_CHK;
`else
    localparam state_t FRAME_END = S_IDLE;
`endif

    state_t      state_q, state_d;
    logic        rw_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic [15:0] idle_cnt_q;
    logic        timeout, push, err_inc;
    logic [24:0] push_entry;

    // A byte arriving in the timeout cycle wins, hence the !rx_valid term.
    assign timeout = (state_q != S_IDLE) && !rx_valid && (idle_cnt_q == TIMEOUT_CYCLES - 16'd1);

`ifdef BRIDGE_FRAME_CHECKSUM_EN
    logic [7:0] chk_exp;
    assign chk_exp = {7'd0, rw_q} ^ addr_q[15:8] ^ addr_q[7:0] ^ data_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rx_valid) begin
            case (state_q)
                S_IDLE:  if (rx_data == SOF_BYTE) state_d = S_CMD;
                S_CMD:   state_d = (rx_data[7:1] == 7'd0) ? S_AHI : S_IDLE;
                S_AHI:   state_d = S_ALO;
                S_ALO:   state_d = rw_q ? S_DATA : FRAME_END;
                S_DATA:  state_d = FRAME_END;
                S_CHK:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        push       = 1'b0;
        err_inc    = 1'b0;
        push_entry = {rw_q, addr_q, data_q};
        if (rx_valid) begin
            case (state_q)
                S_CMD: err_inc = (rx_data[7:1] != 7'd0);
`ifdef BRIDGE_FRAME_CHECKSUM_EN
                S_CHK: begin
                    push    = (rx_data == chk_exp);
                    err_inc = (rx_data != chk_exp);
                end
`else
                S_ALO: begin
                    push       = !rw_q;
                    push_entry = {rw_q, addr_q[15:8], rx_data, 8'h00};
                end
                S_DATA: begin
                    push       = 1'b1;
                    push_entry = {rw_q, addr_q, rx_data};
                end
`endif
                default: ;
            endcase
        end else if (timeout) begin
            err_inc = 1'b1;
        end
    end

    // data_q is cleared at CMD so a read frame carries 8'h00 (and XORs as zero).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q   <= 1'b0;
            addr_q <= 16'h0000;
            data_q <= 8'h00;
        end else if (rx_valid) begin
            case (state_q)
                S_CMD: begin
                    rw_q   <= rx_data[0];
                    data_q <= 8'h00;
                end
                S_AHI:   addr_q[15:8] <= rx_data;
                S_ALO:   addr_q[7:0]  <= rx_data;
                S_DATA:  data_q       <= rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              idle_cnt_q <= 16'd0;
        else if (rx_valid || state_d == S_IDLE)  idle_cnt_q <= 16'd0;
        else                                     idle_cnt_q <= idle_cnt_q + 16'd1;
    end

    // Handshake: the head entry transfers in any cycle with frm_valid && frm_ready; frm_valid
    // never depends on frm_ready and the head fields hold while frm_valid && !frm_ready.
    logic [24:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, pop, push_ok, drop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = frm_valid && frm_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= 8'h00;
            drop_count <= 8'h00;
        end else begin
            if (err_inc && err_count != 8'hFF)  err_count  <= err_count + 8'd1;
            if (drop && drop_count != 8'hFF)    drop_count <= drop_count + 8'd1;
        end
    end

    assign frm_valid = !empty;
    assign {frm_rw, frm_addr, frm_data} = frm_valid ? mem[rd_ptr_q[AW-1:0]] : 25'd0;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bridge_uart_frame_decoder.sv
// Bench for bridge_uart_frame_decoder: directed test-plan frames, randomized frame stream and
// counter saturation, scored against a frame-level queue model of the decoded-request FIFO.
`timescale 1ns/1ps
module tb_bridge_uart_frame_decoder;
    localparam int DEPTH = 4;
    localparam int TMO   = 20;
    localparam logic [7:0] SOF = 8'h7E;
`ifdef BRIDGE_FRAME_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frm_valid, frm_ready, frm_rw, busy;
    logic [15:0] frm_addr;
    logic [7:0]  frm_data, err_count, drop_count;
    logic [2:0]  dbg_state;

    bridge_uart_frame_decoder #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(16'(TMO)),
        .SOF_BYTE      (SOF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .frm_rw    (frm_rw),
        .frm_addr  (frm_addr),
        .frm_data  (frm_data),
        .busy      (busy),
        .err_count (err_count),
        .drop_count(drop_count),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 5 ms");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [24:0] exp_q[$];
    int          err_exp, drop_exp;
    bit          cmp_pending;
    logic [24:0] cmp_entry;
    int          rdy_mode;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Per-cycle model: check the head, then retire a handshake and accept/drop a completed frame.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("frm_valid", frm_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    check("frm_rw", frm_rw, exp_q[0][24]);
                    check("frm_addr", frm_addr, exp_q[0][23:8]);
                    check("frm_data", frm_data, exp_q[0][7:0]);
                end
                if (exp_q.size() != 0 && frm_ready) void'(exp_q.pop_front());
                if (cmp_pending) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(cmp_entry);
                    else                      drop_exp = sat_inc(drop_exp);
                end
            end
        end
    end

    initial begin
        frm_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       frm_ready = 1'b0;
                1:       frm_ready = 1'b1;
                default: frm_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input logic [7:0] d, input bit pend, input logic [24:0] e);
        @(posedge clk); #1;
        rx_valid    = v;
        rx_data     = d;
        cmp_pending = pend;
        cmp_entry   = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b0, 25'd0);
    endtask

    task automatic send_noise(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == SOF) b = 8'h00;
            drive(1'b1, b, 1'b0, 25'd0);
        end
    endtask

    function automatic int pick_gap(input int gap);
        if (gap >= 0) return gap;
        if ($urandom_range(0, 9) == 0) return TMO - 1;
        return $urandom_range(0, 2);
    endfunction

    // kind: 0 good, 1 bad CMD, 2 abandoned mid-frame (timeout), 3 bad checksum
    task automatic send_frame(input bit rw, input logic [15:0] addr, input logic [7:0] data,
                              input int kind, input int gap);
        logic [7:0]  b[6];
        logic [7:0]  cmd, chk;
        logic [24:0] e;
        int          len, cut;
        cmd = {7'd0, rw};
        if (kind == 1) cmd = {7'($urandom_range(1, 127)), rw};
        chk = cmd ^ addr[15:8] ^ addr[7:0] ^ (rw ? data : 8'h00);
        b[0] = SOF; b[1] = cmd; b[2] = addr[15:8]; b[3] = addr[7:0];
        len = 4;
        if (rw) begin b[len] = data; len++; end
        if (CHK_EN) begin
            b[len] = (kind == 3) ? (chk ^ 8'($urandom_range(1, 255))) : chk;
            len++;
        end
        e = {rw, addr, rw ? data : 8'h00};
        case (kind)
            1: begin
                drive(1'b1, b[0], 1'b0, e);
                idle(pick_gap(gap));
                drive(1'b1, b[1], 1'b0, e);
                err_exp = sat_inc(err_exp);
            end
            2: begin
                cut = $urandom_range(1, len - 1);
                for (int i = 0; i < cut; i++) begin
                    if (i > 0) idle(pick_gap(gap));
                    drive(1'b1, b[i], 1'b0, e);
                end
                idle(TMO + $urandom_range(0, 3));
                err_exp = sat_inc(err_exp);
            end
            default: begin
                for (int i = 0; i < len; i++) begin
                    if (i > 0) idle(pick_gap(gap));
                    drive(1'b1, b[i], (kind == 0) && (i == len - 1), e);
                end
                if (kind == 3) err_exp = sat_inc(err_exp);
            end
        endcase
    endtask

    task automatic checkpoint();
        idle(1);
        check("err_count", err_count, err_exp);
        check("drop_count", drop_count, drop_exp);
        check("busy_idle", busy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        cmp_pending = 1'b0;
        exp_q.delete();
        err_exp  = 0;
        drop_exp = 0;
        @(posedge clk); #1;
        check("rst_frm_valid", frm_valid, 1'b0);
        check("rst_frm_rw", frm_rw, 1'b0);
        check("rst_frm_addr", frm_addr, 16'h0000);
        check("rst_frm_data", frm_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_err_count", err_count, 8'h00);
        check("rst_drop_count", drop_count, 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        cmp_pending = 1'b0;
        cmp_entry   = 25'd0;
        rdy_mode    = 0;
        err_exp     = 0;
        drop_exp    = 0;
        do_reset();

        // Write frame, held until a one-cycle ready pulse.
        send_frame(1'b1, 16'h8004, 8'hA5, 0, 0);
        if (!CHK_EN) drive(1'b1, 8'h20, 1'b0, 25'd0);
        checkpoint();
        check("wr_valid", frm_valid, 1'b1);
        check("wr_rw", frm_rw, 1'b1);
        check("wr_addr", frm_addr, 16'h8004);
        check("wr_data", frm_data, 8'hA5);
        rdy_mode = 1;
        idle(1);
        rdy_mode = 0;
        idle(3);

        // Read frame with ready held high.
        rdy_mode = 1;
        send_frame(1'b0, 16'h4010, 8'h00, 0, 0);
        idle(3);
        check("rd_drained", frm_valid, 1'b0);

        // Bad CMD, trailing bytes fall into IDLE as ignored non-SOF bytes.
        drive(1'b1, SOF, 1'b0, 25'd0);
        drive(1'b1, 8'h82, 1'b0, 25'd0);
        err_exp = sat_inc(err_exp);
        send_noise(0);
        drive(1'b1, 8'h80, 1'b0, 25'd0);
        drive(1'b1, 8'h04, 1'b0, 25'd0);
        drive(1'b1, 8'hA5, 1'b0, 25'd0);
        checkpoint();
        check("badcmd_err", err_count, 8'd1);
        send_frame(1'b1, 16'h1234, 8'h5A, 0, -1);
        checkpoint();

        // Timeout after a partial frame.
        drive(1'b1, SOF, 1'b0, 25'd0);
        drive(1'b1, 8'h01, 1'b0, 25'd0);
        drive(1'b1, 8'h80, 1'b0, 25'd0);
        check("busy_mid", busy, 1'b1);
        idle(TMO);
        err_exp = sat_inc(err_exp);
        checkpoint();
        check("tmo_err", err_count, 8'd2);
        send_frame(1'b0, 16'hBEEF, 8'h00, 0, 0);
        checkpoint();

        // Gaps of TMO-1 idle cycles are the longest that must not time out.
        send_frame(1'b1, 16'h7E7E, 8'h7E, 0, TMO - 1);
        checkpoint();
        idle(2);

        // Overfill with ready low: DEPTH retained, two dropped.
        rdy_mode = 0;
        for (int i = 0; i < DEPTH + 2; i++) send_frame(1'b1, 16'hA000 + 16'(i), 8'(i + 1), 0, 0);
        checkpoint();
        check("overfill_drop", drop_count, 8'd2);
        rdy_mode = 1;
        idle(DEPTH + 2);

`ifdef BRIDGE_FRAME_CHECKSUM_EN
        drive(1'b1, SOF, 1'b0, 25'd0);
        drive(1'b1, 8'h01, 1'b0, 25'd0);
        drive(1'b1, 8'h80, 1'b0, 25'd0);
        drive(1'b1, 8'h04, 1'b0, 25'd0);
        drive(1'b1, 8'hA5, 1'b0, 25'd0);
        drive(1'b1, 8'h21, 1'b0, 25'd0);
        err_exp = sat_inc(err_exp);
        checkpoint();
        check("badchk_valid", frm_valid, 1'b0);
`endif

        // Randomized frame stream with random back-pressure.
        rdy_mode = 2;
        for (int n = 0; n < 200; n++) begin
            int r, kind;
            r    = $urandom_range(0, 99);
            kind = (r < 60) ? 0 : (r < 72) ? 1 : (r < 86) ? 2 : (CHK_EN ? 3 : 0);
            send_frame(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), kind, -1);
            if ($urandom_range(0, 3) == 0) send_noise($urandom_range(1, 3));
            checkpoint();
        end

        // Reset mid-frame with queued entries.
        rdy_mode = 0;
        idle(2);
        send_frame(1'b1, 16'h0101, 8'h11, 0, 0);
        send_frame(1'b0, 16'h0202, 8'h00, 0, 0);
        drive(1'b1, SOF, 1'b0, 25'd0);
        drive(1'b1, 8'h01, 1'b0, 25'd0);
        do_reset();
        rdy_mode = 1;
        send_frame(1'b1, 16'hC0DE, 8'h99, 0, 0);
        checkpoint();

        // Saturation of both counters.
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, SOF, 1'b0, 25'd0);
            drive(1'b1, 8'hFE, 1'b0, 25'd0);
            err_exp = sat_inc(err_exp);
        end
        checkpoint();
        check("err_sat", err_count, 8'hFF);
        rdy_mode = 0;
        idle(2);
        for (int i = 0; i < DEPTH + 258; i++) send_frame(1'b0, 16'(i), 8'h00, 0, 0);
        checkpoint();
        check("drop_sat", drop_count, 8'hFF);
        rdy_mode = 1;
        idle(DEPTH + 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bridge_uart_frame_decoder.md
# bridge_uart_frame_decoder

Receive-side framing stage for the UART bus bridge. It consumes the byte stream from a UART receiver, parses fixed-format request frames, and queues complete requests in a small FIFO. The bridge initiator side drains the FIFO through a valid/ready handshake and issues the requests on the local bus. The decoder sits between the UART RX byte output and the bridge initiator request logic.

## Interface
Parameters:
- `FIFO_DEPTH`, 4 — number of queued decoded frames; must be a power of two, ≥ 2.
- `TIMEOUT_CYCLES`, 16'd5000 — maximum idle clock count between bytes of one frame; must be ≥ 2.
- `SOF_BYTE`, 8'h7E — start-of-frame marker.

Ports:
- `clk` input 1 — system clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `rx_data` input 8 — received byte.
- `rx_valid` input 1 — one-cycle strobe; `rx_data` is valid in that cycle. The input cannot be back-pressured.
- `frm_valid` output 1 — FIFO head holds a decoded request.
- `frm_ready` input 1 — consumer accepts the head when `frm_valid && frm_ready`.
- `frm_rw` output 1 — 1 = write, 0 = read.
- `frm_addr` output 16 — target bus address.
- `frm_data` output 8 — write data; 8'h00 for reads.
- `busy` output 1 — parser is mid-frame (state ≠ IDLE).
- `err_count` output 8 — saturating count of malformed, timed-out, or checksum-failed frames.
- `drop_count` output 8 — saturating count of good frames lost because the FIFO was full.

## Operation
- Frame format:
  - Write: SOF, CMD, ADDR_HI, ADDR_LO, DATA, [CHK].
  - Read: SOF, CMD, ADDR_HI, ADDR_LO, [CHK].
- CMD: bit0 = rw; bits[7:1] must be 0.
- Parser FSM states: IDLE, CMD, AHI, ALO, DATA, CHK. Each transition is taken only on `rx_valid`, except timeout.
- IDLE:
  - `SOF_BYTE` → CMD.
  - Any other byte is ignored silently, with no count.
- CMD:
  - Valid CMD latches rw → AHI.
  - Nonzero bits[7:1] → err_count++, IDLE.
- AHI → ALO.
- ALO:
  - If rw=1 → DATA.
  - Otherwise the frame is complete (or CHK state when the feature is enabled).
- DATA: the frame is complete (or CHK state when enabled).
- On completion, {rw, addr, data} is pushed to the FIFO and the FSM returns to IDLE.
- A byte equal to `SOF_BYTE` inside a frame is treated as payload. There is no resynchronisation except by timeout or error.
- Timeout:
  - The idle counter clears on every `rx_valid` and on entry to IDLE.
  - If not IDLE and the counter reaches `TIMEOUT_CYCLES`-1 with no byte → err_count++, IDLE, partial frame discarded.
  - If `rx_valid` arrives in the same cycle as timeout, the byte wins: it is processed and the counter clears.
- FIFO:
  - Show-ahead: head fields are valid whenever `frm_valid`=1.
  - Push while full with a simultaneous pop: the push is accepted.
  - Push while full without a pop: the frame is discarded and drop_count++.
- Counters saturate at 8'hFF.
- Reset mid-frame discards the partial frame and all FIFO contents.

## Timing
- Reset values: `frm_valid`=0, `frm_rw`=0, `frm_addr`=16'h0000, `frm_data`=8'h00, `busy`=0, `err_count`=0, `drop_count`=0. FSM resets to IDLE, FIFO pointers to 0.
- Latency: final byte strobed in cycle N → entry written at the edge ending cycle N → `frm_valid`=1 in cycle N+1 (FIFO previously empty).
- Pop: `frm_valid && frm_ready` in cycle M → next entry (or `frm_valid`=0) from cycle M+1.
- `frm_*` outputs hold stable while `frm_valid && !frm_ready`.
- `busy` rises the cycle after SOF is accepted and falls the cycle after completion, error, or timeout.
- Counters update one cycle after the causing event.
- Back-to-back `rx_valid` on consecutive cycles is supported at full rate.

## Configuration
- `BRIDGE_FRAME_CHECKSUM_EN` defined:
  - Every frame carries a trailing CHK byte = XOR of CMD, ADDR_HI, ADDR_LO, and DATA (writes).
  - Match → push.
  - Mismatch → err_count++, frame discarded.
  - Completion latency is counted from the CHK byte.
- Macro undefined:
  - No CHK state; frames end at ADDR_LO (read) or DATA (write).
  - A CHK byte sent anyway is parsed in IDLE as a non-SOF byte and ignored.

## Test plan
- Write frame 7E 01 80 04 A5 (+CHK 20 when enabled) → one cycle after the last byte: `frm_valid`=1, rw=1, addr=16'h8004, data=8'hA5. Pulse `frm_ready` → `frm_valid`=0 next cycle.
- Read frame 7E 00 40 10 (+CHK 50) with `frm_ready` held high → a single-cycle `frm_valid` with rw=0, addr=16'h4010, data=8'h00.
- Bad CMD 7E 82 ... → err_count=1, no push; a following valid frame decodes correctly.
- Send 7E 01 80, then idle for `TIMEOUT_CYCLES` cycles → err_count=1, `busy`=0; a subsequent full frame decodes correctly.
- Hold `frm_ready`=0 and send `FIFO_DEPTH`+2 valid frames → `FIFO_DEPTH` entries retained in order, drop_count=2.
- With the macro enabled, write frame with CHK=8'h21 → err_count=1, `frm_valid` stays 0.
